// File: rtl/if_id_skid.sv
// IF/ID pipeline stage with a two-entry skid buffer (head H drives decode, skid S absorbs backpressure).
// Optional macro IF_ID_STALL_CNT_EN enables the 32-bit backpressure cycle counter on stall_cnt_o.
module if_id_skid #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32,
  parameter int HOLD_W = 3,
  parameter logic [HOLD_W-1:0] PIPE_CLEAR = HOLD_W'(4)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              valid_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [ADDR_W-1:0] inst_addr_next_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [ADDR_W-1:0] inst_addr_next_o,
  input  logic              ready_i,
  output logic [31:0]       stall_cnt_o
);

  localparam logic [INST_W-1:0] INST_NOP = INST_W'(32'h0000_0013);

  // Handshake: a transfer happens on a rising clk edge where valid and ready are both high;
  // valid never depends on ready, and ready_o/valid_o come straight from the state flops.
  // State bits are {H.valid, S.valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    H_HOLD,
    H_IN,
    H_SKID
  } h_sel_t;

  state_t      state_q, next_state;
  h_sel_t      h_sel;
  logic        s_load;
  logic        push, pop, flush;

  logic [INST_W-1:0] s_inst_q;
  logic [ADDR_W-1:0] s_addr_q, s_addr_next_q;

  assign valid_o = state_q[1];
  assign ready_o = ~state_q[0];
  assign flush   = (hold_flag_i == PIPE_CLEAR);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    h_sel      = H_HOLD;
    s_load     = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            next_state = ONE;
            h_sel      = H_IN;
          end
        end
        ONE: begin
          if (push && pop) begin
            h_sel = H_IN;
          end else if (push) begin
            next_state = FULL;
            s_load     = 1'b1;
          end else if (pop) begin
            next_state = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            next_state = ONE;
            h_sel      = H_SKID;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  // Head payload is forced to NOP/zero whenever the head goes invalid, so outputs need no gating.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !next_state[1]) begin
      inst_o           <= INST_NOP;
      inst_addr_o      <= '0;
      inst_addr_next_o <= '0;
    end else begin
      case (h_sel)
        H_IN: begin
          inst_o           <= inst_i;
          inst_addr_o      <= inst_addr_i;
          inst_addr_next_o <= inst_addr_next_i;
        end
        H_SKID: begin
          inst_o           <= s_inst_q;
          inst_addr_o      <= s_addr_q;
          inst_addr_next_o <= s_addr_next_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush) begin
      s_inst_q      <= '0;
      s_addr_q      <= '0;
      s_addr_next_q <= '0;
    end else if (s_load) begin
      s_inst_q      <= inst_i;
      s_addr_q      <= inst_addr_i;
      s_addr_next_q <= inst_addr_next_i;
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                stall_cnt_q <= '0;
    else if (valid_o && !ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: streaming, backpressure, flush, mid-operation reset, stall counter.
module tb_if_id_skid;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [2:0]  CLEAR = 3'b100;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [2:0]  hold_flag_i;
  logic        valid_i;
  logic [31:0] inst_i, inst_addr_i, inst_addr_next_i;
  logic        ready_o, valid_o, ready_i;
  logic [31:0] inst_o, inst_addr_o, inst_addr_next_o, stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_stall = 32'd0;

  always #5 clk = ~clk;

  if_id_skid dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .hold_flag_i      (hold_flag_i),
    .valid_i          (valid_i),
    .inst_i           (inst_i),
    .inst_addr_i      (inst_addr_i),
    .inst_addr_next_i (inst_addr_next_i),
    .ready_o          (ready_o),
    .valid_o          (valid_o),
    .inst_o           (inst_o),
    .inst_addr_o      (inst_addr_o),
    .inst_addr_next_o (inst_addr_next_o),
    .ready_i          (ready_i),
    .stall_cnt_o      (stall_cnt_o)
  );

  // Advance one edge; stall expectation follows the state seen just before the edge.
  task automatic tick();
`ifdef IF_ID_STALL_CNT_EN
    if (rst_ni && valid_o && !ready_i) exp_stall = exp_stall + 32'd1;
    if (!rst_ni) exp_stall = 32'd0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    valid_i          = v;
    inst_i           = inst;
    inst_addr_i      = pc;
    inst_addr_next_i = pc + 32'd4;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc, input logic rdy);
    check({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    check({tag, "_inst"}, inst_o, v ? inst : NOP);
    check({tag, "_addr"}, inst_addr_o, v ? pc : 32'd0);
    check({tag, "_next"}, inst_addr_next_o, v ? pc + 32'd4 : 32'd0);
    check({tag, "_ready"}, {31'd0, ready_o}, {31'd0, rdy});
    check({tag, "_stall"}, stall_cnt_o, exp_stall);
  endtask

  initial begin
    rst_ni = 1'b0; hold_flag_i = 3'd0; ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    rst_ni = 1'b1;
    check_head("reset", 1'b0, NOP, 32'h0, 1'b1);

    // Streaming at full rate
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA000_0000 + i, 32'(4 * i));
      tick();
      check_head($sformatf("stream%0d", i), 1'b1, 32'hA000_0000 + i, 32'(4 * i), 1'b1);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_head("stream_drain", 1'b0, NOP, 32'h0, 1'b1);

    // Backpressure fills the skid, then drains in order
    ready_i = 1'b0;
    drive(1'b1, 32'hA0, 32'h100);
    tick();
    check_head("bp_a0", 1'b1, 32'hA0, 32'h100, 1'b1);
    drive(1'b1, 32'hA1, 32'h104);
    tick();
    check_head("bp_full", 1'b1, 32'hA0, 32'h100, 1'b0);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_head("bp_hold", 1'b1, 32'hA0, 32'h100, 1'b0);
    ready_i = 1'b1;
    tick();
    check_head("bp_pop_a0", 1'b1, 32'hA1, 32'h104, 1'b1);
    tick();
    check_head("bp_pop_a1", 1'b0, NOP, 32'h0, 1'b1);

    // Flush from FULL with a pending fetch
    ready_i = 1'b0;
    drive(1'b1, 32'hB0, 32'h200);
    tick();
    drive(1'b1, 32'hB1, 32'h204);
    tick();
    check_head("fl_full", 1'b1, 32'hB0, 32'h200, 1'b0);
    hold_flag_i = CLEAR;
    drive(1'b1, 32'hA2, 32'h208);
    tick();
    check_head("fl_flush", 1'b0, NOP, 32'h0, 1'b1);
    hold_flag_i = 3'd0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_head("fl_after", 1'b0, NOP, 32'h0, 1'b1);

    // Flush in ONE drops the push made in the same cycle
    drive(1'b1, 32'hC0, 32'h300);
    tick();
    check_head("fl1_one", 1'b1, 32'hC0, 32'h300, 1'b1);
    hold_flag_i = CLEAR;
    drive(1'b1, 32'hC1, 32'h304);
    tick();
    check_head("fl1_flush", 1'b0, NOP, 32'h0, 1'b1);
    hold_flag_i = 3'd1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_head("fl1_after", 1'b0, NOP, 32'h0, 1'b1);
    hold_flag_i = 3'd0;

    // Reset while FULL
    drive(1'b1, 32'hE0, 32'h400);
    tick();
    drive(1'b1, 32'hE1, 32'h404);
    tick();
    check_head("rst_full", 1'b1, 32'hE0, 32'h400, 1'b0);
    rst_ni = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    rst_ni = 1'b1;
    check_head("rst_mid", 1'b0, NOP, 32'h0, 1'b1);
    drive(1'b1, 32'hF0, 32'h500);
    tick();
    check_head("rst_push", 1'b1, 32'hF0, 32'h500, 1'b1);

    // Five stalled cycles with a valid head
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    check_head("stall5", 1'b1, 32'hF0, 32'h500, 1'b1);
`ifdef IF_ID_STALL_CNT_EN
    check("stall5_abs", stall_cnt_o, 32'd5);
`else
    check("stall5_abs", stall_cnt_o, 32'd0);
`endif
    ready_i = 1'b1;
    tick();
    check_head("stall_pop", 1'b0, NOP, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
